// File: rtl/sump_responder.sv
// SUMP/OLS reply generator: serializes ID, metadata and input-snapshot replies
// onto the UART TX byte interface with XON/XOFF flow control and soft reset.
module sump_responder #(
    parameter int unsigned MEM_BYTES  = 24576,
    parameter int unsigned SMPL_RATE  = 200000000,
    parameter int unsigned NUM_PROBES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  cmd_i,
    input  logic        cmd_stb_i,
    input  logic [31:0] smpl_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_stb_o,
    input  logic        tx_rdy_i,
    output logic        busy_o
);

    localparam logic [7:0] OP_SOFT_RST = 8'h00;
    localparam logic [7:0] OP_ID       = 8'h02;
    localparam logic [7:0] OP_META     = 8'h04;
    localparam logic [7:0] OP_INPUT    = 8'h06;
    localparam logic [7:0] OP_XON      = 8'h11;
    localparam logic [7:0] OP_XOFF     = 8'h13;

    localparam logic [31:0] MEM_W  = 32'(MEM_BYTES);
    localparam logic [31:0] RATE_W = 32'(SMPL_RATE);
    localparam logic [7:0]  NUM_B  = 8'(NUM_PROBES);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    typedef enum logic [1:0] {
        R_ID,
        R_INPUT,
        R_META
    } reply_t;

    state_t      state_q, state_d;
    reply_t      kind_q, kind_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] snap_q, snap_d;
    logic        xoff_q, xoff_d;
    logic        stb_q, stb_d;
    logic        start;
    logic        soft_rst;
    logic        xfer;
    logic [7:0]  rom_byte;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        idx_d    = idx_q;
        len_d    = len_q;
        snap_d   = snap_q;
        xoff_d   = xoff_q;
        stb_d    = stb_q;
        start    = 1'b0;
        soft_rst = cmd_stb_i && (cmd_i == OP_SOFT_RST);
        xfer     = stb_q && tx_rdy_i;

        // Flow-control opcodes are honoured in every state
        if (cmd_stb_i && (cmd_i == OP_XON)) begin
            xoff_d = 1'b0;
        end else if (cmd_stb_i && (cmd_i == OP_XOFF)) begin
            xoff_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_stb_i) begin
                    case (cmd_i)
                        OP_ID: begin
                            start  = 1'b1;
                            kind_d = R_ID;
                            len_d  = 5'd3;
                        end
                        OP_INPUT: begin
                            start  = 1'b1;
                            kind_d = R_INPUT;
                            len_d  = 5'd3;
                            snap_d = smpl_i;
                        end
                        OP_META: begin
                            start  = 1'b1;
                            kind_d = R_META;
                            len_d  = 5'd31;
                        end
                        default: ;
                    endcase
                end
                if (start) begin
                    state_d = SEND;
                    idx_d   = '0;
                    stb_d   = ~xoff_d;
                end
            end
            SEND: begin
                // A pending strobe is never retracted except by soft reset
                if (soft_rst) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    stb_d   = 1'b0;
                end else if (xfer) begin
                    if (idx_q == len_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        stb_d   = 1'b0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        stb_d = ~xoff_d;
                    end
                end else if (!stb_q) begin
                    stb_d = ~xoff_d;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rom_byte = '0;
        unique case (kind_q)
            R_ID: begin
                case (idx_q[1:0])
                    2'd0:    rom_byte = 8'h31;
                    2'd1:    rom_byte = 8'h41;
                    2'd2:    rom_byte = 8'h4C;
                    default: rom_byte = 8'h53;
                endcase
            end
            R_INPUT: begin
                case (idx_q[1:0])
                    2'd0:    rom_byte = snap_q[7:0];
                    2'd1:    rom_byte = snap_q[15:8];
                    2'd2:    rom_byte = snap_q[23:16];
                    default: rom_byte = snap_q[31:24];
                endcase
            end
            R_META: begin
                case (idx_q)
                    5'd0:    rom_byte = 8'h01;
                    5'd1:    rom_byte = 8'h4C;
                    5'd2:    rom_byte = 8'h6F;
                    5'd3:    rom_byte = 8'h67;
                    5'd4:    rom_byte = 8'h49;
                    5'd5:    rom_byte = 8'h50;
                    5'd6:    rom_byte = 8'h20;
                    5'd7:    rom_byte = 8'h76;
                    5'd8:    rom_byte = 8'h30;
                    5'd9:    rom_byte = 8'h2E;
                    5'd10:   rom_byte = 8'h31;
                    5'd11:   rom_byte = 8'h00;
                    5'd12:   rom_byte = 8'h02;
                    5'd13:   rom_byte = 8'h30;
                    5'd14:   rom_byte = 8'h2E;
                    5'd15:   rom_byte = 8'h31;
                    5'd16:   rom_byte = 8'h00;
                    5'd17:   rom_byte = 8'h21;
                    5'd18:   rom_byte = MEM_W[31:24];
                    5'd19:   rom_byte = MEM_W[23:16];
                    5'd20:   rom_byte = MEM_W[15:8];
                    5'd21:   rom_byte = MEM_W[7:0];
                    5'd22:   rom_byte = 8'h23;
                    5'd23:   rom_byte = RATE_W[31:24];
                    5'd24:   rom_byte = RATE_W[23:16];
                    5'd25:   rom_byte = RATE_W[15:8];
                    5'd26:   rom_byte = RATE_W[7:0];
                    5'd27:   rom_byte = 8'h40;
                    5'd28:   rom_byte = NUM_B;
                    5'd29:   rom_byte = 8'h41;
                    5'd30:   rom_byte = 8'h02;
                    default: rom_byte = 8'h00;
                endcase
            end
            default: rom_byte = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            kind_q  <= R_ID;
            idx_q   <= '0;
            len_q   <= '0;
            snap_q  <= '0;
            xoff_q  <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            snap_q  <= snap_d;
            xoff_q  <= xoff_d;
            stb_q   <= stb_d;
        end
    end

    assign tx_data_o = (state_q == SEND) ? rom_byte : '0;
    assign tx_stb_o  = stb_q;
    assign busy_o    = (state_q == SEND);

endmodule

// File: tb/tb_sump_responder.sv
// Directed bench for sump_responder: expected reply bytes are queued when a
// command is issued and compared as each handshake completes.
module tb_sump_responder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  cmd_i = '0;
    logic        cmd_stb_i = 1'b0;
    logic [31:0] smpl_i = '0;
    logic [7:0]  tx_data_o;
    logic        tx_stb_o;
    logic        tx_rdy_i = 1'b0;
    logic        busy_o;

    sump_responder #(
        .MEM_BYTES (24576),
        .SMPL_RATE (200000000),
        .NUM_PROBES(32)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cmd_i    (cmd_i),
        .cmd_stb_i(cmd_stb_i),
        .smpl_i   (smpl_i),
        .tx_data_o(tx_data_o),
        .tx_stb_o (tx_stb_o),
        .tx_rdy_i (tx_rdy_i),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned n_xfer   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  meta[32];
    logic [7:0]  id_bytes[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score a handshake at the coming edge, then check stall hold.
    task automatic step();
        logic       stalled;
        logic [7:0] held;
        logic [7:0] e;
        stalled = tx_stb_o && !tx_rdy_i && !rst_i && !(cmd_stb_i && cmd_i == 8'h00);
        held    = tx_data_o;
        if (tx_stb_o && tx_rdy_i && !rst_i) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'(tx_data_o), 32'hxxxx_xx00 | 32'h100);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", 32'(tx_data_o), 32'(e));
            end
        end
        @(posedge clk_i);
        #1;
        cmd_stb_i = 1'b0;
        if (stalled) begin
            check("stall_data", 32'(tx_data_o), 32'(held));
            check("stall_stb", 32'(tx_stb_o), 32'd1);
        end
    endtask

    task automatic issue(input logic [7:0] c);
        cmd_i     = c;
        cmd_stb_i = 1'b1;
        step();
    endtask

    task automatic push_id();
        for (int i = 0; i < 4; i++) exp_q.push_back(id_bytes[i]);
    endtask

    task automatic drain(input bit rnd);
        int unsigned budget;
        budget = 0;
        while ((exp_q.size() != 0 || busy_o) && budget < 300) begin
            tx_rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            budget++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy_o), 32'd0);
        check("drain_stb", 32'(tx_stb_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        meta = '{8'h01, 8'h4C, 8'h6F, 8'h67, 8'h49, 8'h50, 8'h20, 8'h76,
                 8'h30, 8'h2E, 8'h31, 8'h00, 8'h02, 8'h30, 8'h2E, 8'h31,
                 8'h00, 8'h21, 8'h00, 8'h00, 8'h60, 8'h00, 8'h23, 8'h0B,
                 8'hEB, 8'hC2, 8'h00, 8'h40, 8'h20, 8'h41, 8'h02, 8'h00};
        id_bytes = '{8'h31, 8'h41, 8'h4C, 8'h53};

        // Reset values
        rst_i = 1'b1;
        step();
        step();
        check("rst_stb", 32'(tx_stb_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", 32'(tx_data_o), 32'd0);
        rst_i = 1'b0;
        step();

        // ID query, full throughput
        tx_rdy_i = 1'b1;
        push_id();
        issue(8'h02);
        for (int i = 0; i < 4; i++) begin
            check("id_stb", 32'(tx_stb_o), 32'd1);
            check("id_busy", 32'(busy_o), 32'd1);
            step();
        end
        check("id_done_busy", 32'(busy_o), 32'd0);
        check("id_done_stb", 32'(tx_stb_o), 32'd0);
        check("id_left", 32'(exp_q.size()), 32'd0);

        // Input query with snapshot frozen at accept
        smpl_i = 32'hDEADBEEF;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hDE);
        issue(8'h06);
        smpl_i = '0;
        drain(1'b0);

        // Metadata with random ready and stall-hold checks
        for (int i = 0; i < 32; i++) exp_q.push_back(meta[i]);
        n_xfer = 0;
        issue(8'h04);
        drain(1'b1);
        check("meta_count", n_xfer, 32'd32);

        // XOFF while byte 3 is pending
        tx_rdy_i = 1'b1;
        push_id();
        issue(8'h02);
        step();
        step();
        tx_rdy_i = 1'b0;
        check("xoff_pending", 32'(tx_data_o), 32'h4C);
        issue(8'h13);
        step();
        step();
        tx_rdy_i = 1'b1;
        step();
        check("xoff_held_stb", 32'(tx_stb_o), 32'd0);
        check("xoff_held_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("xoff_no_stb", 32'(tx_stb_o), 32'd0);
        end
        issue(8'h11);
        check("xon_stb", 32'(tx_stb_o), 32'd1);
        check("xon_data", 32'(tx_data_o), 32'h53);
        drain(1'b0);

        // Soft reset during metadata at index 10
        for (int i = 0; i < 10; i++) exp_q.push_back(meta[i]);
        tx_rdy_i = 1'b1;
        issue(8'h04);
        for (int i = 0; i < 10; i++) step();
        check("sr_at_idx10", 32'(tx_data_o), 32'(meta[10]));
        tx_rdy_i = 1'b0;
        issue(8'h00);
        check("sr_stb", 32'(tx_stb_o), 32'd0);
        check("sr_busy", 32'(busy_o), 32'd0);
        check("sr_left", 32'(exp_q.size()), 32'd0);
        push_id();
        issue(8'h02);
        check("sr_restart", 32'(tx_data_o), 32'h31);
        drain(1'b0);

        // Input query during ID reply is dropped
        tx_rdy_i = 1'b1;
        push_id();
        issue(8'h02);
        step();
        smpl_i = 32'h12345678;
        issue(8'h06);
        drain(1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("drop_idle_busy", 32'(busy_o), 32'd0);
        end

        // rst_i mid-reply, also clearing an active XOFF
        for (int i = 0; i < 3; i++) exp_q.push_back(meta[i]);
        issue(8'h04);
        for (int i = 0; i < 3; i++) step();
        tx_rdy_i = 1'b0;
        issue(8'h13);
        rst_i = 1'b1;
        step();
        check("rst_mid_stb", 32'(tx_stb_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_data", 32'(tx_data_o), 32'd0);
        rst_i = 1'b0;
        push_id();
        issue(8'h02);
        check("rst_xon_stb", 32'(tx_stb_o), 32'd1);
        drain(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
